// File: rtl/loader_pkg.sv
// loader_pkg: encodings, command byte and bit-timing helper for uart_loader.
// P_ACK only exists when LOADER_ACK_EN is defined.
package loader_pkg;

    localparam logic [7:0] CMD_WRITE = 8'h57;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAITHI
    } rx_state_t;

    typedef enum logic [2:0] {
        P_CMD,
        P_A0,
        P_A1,
        P_A2,
        P_L0,
        P_L1,
        P_DATA
`ifdef LOADER_ACK_EN
        , P_ACK
`endif
    } pkt_state_t;

    function automatic int clks_per_bit(input int clock_hz, input int baud);
        return clock_hz / baud;
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 8N1 receiver with rx synchroniser, glitch reject and
// framing detection; strobes are single-cycle and registered.
module uart_rx_byte
    import loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 217
) (
    input  logic       i_clock,
    input  logic       i_reset,
    input  logic       i_rx,
    output logic       o_byte_valid,
    output logic [7:0] o_byte,
    output logic       o_frame_err
);

    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    logic          r_sync1;
    logic          r_sync2;
    rx_state_t     r_state;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_bit;
    logic [7:0]    r_shift;
    logic          w_full;
    logic          w_half;

    assign w_full = (r_cnt == FULL_LAST);
    assign w_half = (r_cnt == HALF_LAST);

    // two-flop synchroniser; idle-high so reset to 1
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= i_rx;
            r_sync2 <= r_sync1;
        end
    end

    // receiver FSM with bit timer, shift register and strobes
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state      <= RX_IDLE;
            r_cnt        <= '0;
            r_bit        <= '0;
            r_shift      <= '0;
            o_byte_valid <= 1'b0;
            o_byte       <= '0;
            o_frame_err  <= 1'b0;
        end else begin
            o_byte_valid <= 1'b0;
            o_frame_err  <= 1'b0;
            case (r_state)
                RX_IDLE: begin
                    r_cnt <= '0;
                    if (!r_sync2) r_state <= RX_START;
                end
                RX_START: begin
                    if (w_half) begin
                        r_cnt   <= '0;
                        r_bit   <= '0;
                        r_state <= r_sync2 ? RX_IDLE : RX_DATA;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (w_full) begin
                        r_cnt   <= '0;
                        r_shift <= {r_sync2, r_shift[7:1]};
                        r_bit   <= r_bit + 3'd1;
                        if (r_bit == 3'd7) r_state <= RX_STOP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (w_full) begin
                        r_cnt <= '0;
                        if (r_sync2) begin
                            o_byte_valid <= 1'b1;
                            o_byte       <= r_shift;
                            r_state      <= RX_IDLE;
                        end else begin
                            o_frame_err <= 1'b1;
                            r_state     <= RX_WAITHI;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                RX_WAITHI: begin
                    if (r_sync2) r_state <= RX_IDLE;
                end
                default: r_state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_loader.sv
// uart_loader: parses 'W' write packets from the host UART into byte writes.
// Define LOADER_ACK_EN to return an 8N1 checksum byte on tx per packet.
module uart_loader
    import loader_pkg::*;
#(
    parameter int CLOCK_HZ     = 25000000,
    parameter int BAUD         = 115200,
    parameter int TIMEOUT_BITS = 64
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        rx,
    output logic        tx,
    output logic [19:0] address,
    output logic [7:0]  out,
    output logic        we,
    output logic        busy,
    output logic        error
);

    localparam int CPB = clks_per_bit(CLOCK_HZ, BAUD);
    localparam int TMO = TIMEOUT_BITS * CPB;
    localparam int TW  = $clog2(TMO + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TMO - 1);

    logic        w_byte_valid;
    logic [7:0]  w_byte;
    logic        w_frame_err;
    logic        w_len_zero;
    logic        w_last_data;
    logic        w_pkt_end;
    logic        w_abort;

    pkt_state_t  r_state;
    logic [19:0] r_addr;
    logic [7:0]  r_out;
    logic        r_we;
    logic        r_busy;
    logic        r_error;
    logic [19:0] r_base;
    logic [15:0] r_len;
    logic [15:0] r_idx;
    logic [TW-1:0] r_tmo;

`ifdef LOADER_ACK_EN
    localparam int CW = $clog2(CPB + 1);
    localparam logic [CW-1:0] CPB_LAST = CW'(CPB - 1);

    logic [7:0]    r_sum;
    logic [7:0]    w_sum_next;
    logic          r_tx;
    logic [8:0]    r_tx_shift;
    logic [3:0]    r_tx_bit;
    logic [CW-1:0] r_tx_cnt;

    assign w_sum_next = (r_state == P_DATA) ? r_sum + w_byte : r_sum;
    assign tx = r_tx;
`else
    assign tx = 1'b1;
`endif

    uart_rx_byte #(
        .CLKS_PER_BIT(CPB)
    ) u_rx (
        .i_clock     (clock),
        .i_reset     (reset),
        .i_rx        (rx),
        .o_byte_valid(w_byte_valid),
        .o_byte      (w_byte),
        .o_frame_err (w_frame_err)
    );

    assign w_len_zero  = ({w_byte, r_len[7:0]} == 16'd0);
    assign w_last_data = ((r_idx + 16'd1) == r_len);
    assign w_pkt_end   = w_byte_valid &&
                         ((r_state == P_L1 && w_len_zero) ||
                          (r_state == P_DATA && w_last_data));
    assign w_abort     = (r_state != P_CMD) &&
                         (w_frame_err ||
                          (!w_byte_valid && r_tmo == TMO_LAST));

    assign address = r_addr;
    assign out     = r_out;
    assign we      = r_we;
    assign busy    = r_busy;
    assign error   = r_error;

    // packet FSM: header parse, write strobe, timeout/abort, ack transmit
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= P_CMD;
            r_addr  <= '0;
            r_out   <= '0;
            r_we    <= 1'b0;
            r_busy  <= 1'b0;
            r_error <= 1'b0;
            r_base  <= '0;
            r_len   <= '0;
            r_idx   <= '0;
            r_tmo   <= '0;
`ifdef LOADER_ACK_EN
            r_sum      <= '0;
            r_tx       <= 1'b1;
            r_tx_shift <= '0;
            r_tx_bit   <= '0;
            r_tx_cnt   <= '0;
`endif
        end else begin
            r_we <= 1'b0;
            if (r_state == P_CMD || w_byte_valid) r_tmo <= '0;
            else r_tmo <= r_tmo + 1'b1;
            if (w_frame_err) r_error <= 1'b1;
            // busy trails the final write by one cycle
            if (r_state == P_CMD) r_busy <= 1'b0;

            if (w_byte_valid) begin
                case (r_state)
                    P_CMD: begin
                        if (w_byte == CMD_WRITE) begin
                            r_busy  <= 1'b1;
                            r_error <= 1'b0;
                            r_state <= P_A0;
`ifdef LOADER_ACK_EN
                            r_sum <= '0;
`endif
                        end
                    end
                    P_A0: begin
                        r_base[7:0] <= w_byte;
                        r_state     <= P_A1;
                    end
                    P_A1: begin
                        r_base[15:8] <= w_byte;
                        r_state      <= P_A2;
                    end
                    P_A2: begin
                        r_base[19:16] <= w_byte[3:0];
                        r_state       <= P_L0;
                    end
                    P_L0: begin
                        r_len[7:0] <= w_byte;
                        r_state    <= P_L1;
                    end
                    P_L1: begin
                        r_len[15:8] <= w_byte;
                        r_idx       <= '0;
                        r_state     <= P_DATA;
                    end
                    P_DATA: begin
                        r_addr <= r_base + {4'b0, r_idx};
                        r_out  <= w_byte;
                        r_we   <= 1'b1;
                        r_idx  <= r_idx + 16'd1;
`ifdef LOADER_ACK_EN
                        r_sum <= w_sum_next;
`endif
                    end
                    default: ;
                endcase
            end

            if (w_pkt_end) begin
`ifdef LOADER_ACK_EN
                r_state    <= P_ACK;
                r_tx       <= 1'b0;
                r_tx_shift <= {1'b1, w_sum_next};
                r_tx_bit   <= '0;
                r_tx_cnt   <= '0;
`else
                r_state <= P_CMD;
`endif
            end

`ifdef LOADER_ACK_EN
            // start bit, 8 data bits LSB first, then stop bit
            if (r_state == P_ACK) begin
                if (r_tx_cnt == CPB_LAST) begin
                    r_tx_cnt <= '0;
                    if (r_tx_bit == 4'd9) begin
                        r_busy  <= 1'b0;
                        r_state <= P_CMD;
                    end else begin
                        r_tx       <= r_tx_shift[0];
                        r_tx_shift <= {1'b0, r_tx_shift[8:1]};
                        r_tx_bit   <= r_tx_bit + 4'd1;
                    end
                end else begin
                    r_tx_cnt <= r_tx_cnt + 1'b1;
                end
            end
`endif

            if (w_abort) begin
                r_state <= P_CMD;
                r_busy  <= 1'b0;
                r_error <= 1'b1;
`ifdef LOADER_ACK_EN
                r_tx <= 1'b1;
`endif
            end
        end
    end

endmodule

// File: tb/tb_uart_loader.sv
// tb_uart_loader: randomized and directed packets against a queue-based
// packet model; LOADER_ACK_EN adds a tx decoder for the checksum byte.
module tb_uart_loader;

    localparam int CPB = 16;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        rx    = 1'b1;
    logic        tx;
    logic [19:0] address;
    logic [7:0]  out;
    logic        we;
    logic        busy;
    logic        error;

    always #5 clock = ~clock;

    uart_loader #(
        .CLOCK_HZ    (1600000),
        .BAUD        (100000),
        .TIMEOUT_BITS(64)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .rx     (rx),
        .tx     (tx),
        .address(address),
        .out    (out),
        .we     (we),
        .busy   (busy),
        .error  (error)
    );

    typedef struct {
        logic [19:0] a;
        logic [7:0]  d;
        bit          last;
    } wr_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    wr_t         exp_q[$];
    logic [27:0] log_q[$];
    logic [7:0]  pkt_q[$];
    logic [7:0]  ack_q[$];
    logic [7:0]  last_ack = 8'h00;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // expected writes/ack for the first n_sent bytes of pkt_q
    function automatic bit model_packet(input int n_sent);
        int   base;
        int   len;
        int   ndata;
        bit   complete;
        wr_t  w;
        logic [7:0] sum;
        if (n_sent < 6) return 1'b0;
        base = int'(pkt_q[1]) + (int'(pkt_q[2]) << 8) +
               (int'(pkt_q[3] & 8'h0F) << 16);
        len  = int'(pkt_q[4]) + (int'(pkt_q[5]) << 8);
        ndata = n_sent - 6;
        if (ndata > len) ndata = len;
        complete = (n_sent - 6 >= len);
        sum = 8'h00;
        for (int i = 0; i < ndata; i++) begin
            w.a    = 20'((base + i) % (1 << 20));
            w.d    = pkt_q[6 + i];
            w.last = complete && (i == len - 1);
            exp_q.push_back(w);
            sum = sum + pkt_q[6 + i];
        end
`ifdef LOADER_ACK_EN
        if (complete) ack_q.push_back(sum);
`else
        if (sum == 8'h00) sum = 8'h01;
`endif
        return complete;
    endfunction

    // compare process: every write strobe against the model queue
    bit chk_drop = 1'b0;
    always @(negedge clock) begin
        wr_t e;
        if (chk_drop) begin
`ifdef LOADER_ACK_EN
            check("busy_after_last_we", busy, 1);
`else
            check("busy_after_last_we", busy, 0);
`endif
            chk_drop = 1'b0;
        end
        if (we === 1'b1) begin
            log_q.push_back({address, out});
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_we: got %h<-%h, required none",
                         address, out);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", address, e.a);
                check("wr_data", out, e.d);
                check("busy_at_we", busy, 1);
                if (e.last) chk_drop = 1'b1;
            end
        end
    end

`ifdef LOADER_ACK_EN
    // decode ack bytes from tx and compare with the model checksum
    initial begin : tx_mon
        logic [7:0] b;
        forever begin
            @(negedge tx);
            repeat (CPB / 2) @(posedge clock);
            #1;
            check("tx_start", tx, 0);
            for (int i = 0; i < 8; i++) begin
                repeat (CPB) @(posedge clock);
                #1;
                b[i] = tx;
            end
            repeat (CPB) @(posedge clock);
            #1;
            check("tx_stop", tx, 1);
            check("busy_in_stop", busy, 1);
            if (ack_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_ack: got %h, required none", b);
            end else begin
                check("ack_byte", b, ack_q.pop_front());
            end
            last_ack = b;
        end
    end
`endif

    task automatic send_byte(input logic [7:0] b, input bit stop_ok);
        @(negedge clock);
        rx = 1'b0;
        repeat (CPB) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clock);
        end
        rx = stop_ok;
        repeat (CPB) @(negedge clock);
        rx = 1'b1;
    endtask

    task automatic wait_busy_low(input int budget);
        int k = 0;
        while (busy !== 1'b0 && k < budget) begin
            @(negedge clock);
            k++;
        end
        if (busy !== 1'b0) begin
            n_checks++;
            n_fail++;
            $display("FAIL busy_wait: busy %b after %0d cycles, required 0",
                     busy, budget);
        end
    endtask

    task automatic finish_packet();
`ifdef LOADER_ACK_EN
        check("busy_during_ack", busy, 1);
        wait_busy_low(12 * CPB);
`endif
        check("busy_end", busy, 0);
        check("error_end", error, 0);
    endtask

    task automatic run_packet(input int n_send);
        bit complete;
        complete = model_packet(n_send);
        for (int i = 0; i < n_send; i++) begin
            send_byte(pkt_q[i], 1'b1);
            if (i == 0) begin
                check("busy_after_W", busy, 1);
                check("error_after_W", error, 0);
            end
        end
        if (complete) finish_packet();
    endtask

    initial begin
        logic [7:0] b;
        int len;
        bit ok;
        repeat (4) @(negedge clock);
        check("rst_address", address, 0);
        check("rst_out", out, 0);
        check("rst_we", we, 0);
        check("rst_busy", busy, 0);
        check("rst_error", error, 0);
        check("rst_tx", tx, 1);
        reset = 1'b0;
        repeat (4) @(negedge clock);

        // basic three-byte write
        log_q = {};
        pkt_q = {8'h57, 8'h00, 8'hE0, 8'h0F, 8'h03, 8'h00,
                 8'hAA, 8'hBB, 8'hCC};
        run_packet(9);
        check("s1_nwr", log_q.size(), 3);
        check("s1_wr0", log_q[0], {20'hFE000, 8'hAA});
        check("s1_wr1", log_q[1], {20'hFE001, 8'hBB});
        check("s1_wr2", log_q[2], {20'hFE002, 8'hCC});
`ifdef LOADER_ACK_EN
        check("s1_ack", last_ack, 8'h31);
`endif

        // address wrap at the top of the 20-bit space
        log_q = {};
        pkt_q = {8'h57, 8'hFF, 8'hFF, 8'h0F, 8'h02, 8'h00, 8'h11, 8'h22};
        run_packet(8);
        check("s2_wr0", log_q[0], {20'hFFFFF, 8'h11});
        check("s2_wr1", log_q[1], {20'h00000, 8'h22});

        // stray bytes ignored, then a zero-length packet
        log_q = {};
        send_byte(8'h13, 1'b1);
        check("noise13_busy", busy, 0);
        send_byte(8'h41, 1'b1);
        check("noise41_busy", busy, 0);
        pkt_q = {8'h57, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        run_packet(6);
        check("s3_nwr", log_q.size(), 0);

        // timeout after one of five data bytes
        log_q = {};
        pkt_q = {8'h57, 8'h00, 8'h00, 8'h00, 8'h05, 8'h00, 8'h01};
        run_packet(7);
        check("tmo_busy_pending", busy, 1);
        repeat (60 * CPB) @(negedge clock);
        check("tmo_busy_early", busy, 1);
        wait_busy_low(8 * CPB);
        check("tmo_error", error, 1);
        check("tmo_nwr", log_q.size(), 1);
        check("tmo_wr0", log_q[0], {20'h00000, 8'h01});
        pkt_q = {8'h57, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        run_packet(6);

        // framing error mid-packet aborts
        pkt_q = {8'h57, 8'h00};
        run_packet(2);
        send_byte(8'h33, 1'b0);
        repeat (2 * CPB) @(negedge clock);
        check("frm_error", error, 1);
        check("frm_busy", busy, 0);

        // short low glitch mid-packet produces no byte
        log_q = {};
        pkt_q = {8'h57, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h5A};
        ok = model_packet(7);
        for (int i = 0; i < 6; i++) send_byte(pkt_q[i], 1'b1);
        rx = 1'b0;
        repeat (4) @(negedge clock);
        rx = 1'b1;
        repeat (2 * CPB) @(negedge clock);
        check("glitch_busy", busy, 1);
        check("glitch_error", error, 0);
        send_byte(pkt_q[6], 1'b1);
        if (ok) finish_packet();
        check("glitch_nwr", log_q.size(), 1);

        // randomized packets with stray bytes between them
        for (int it = 0; it < 10; it++) begin
            if ($urandom_range(0, 1) == 1) begin
                b = 8'($urandom_range(0, 255));
                if (b == 8'h57) b = 8'h56;
                send_byte(b, 1'b1);
                check("rnd_noise_busy", busy, 0);
            end
            len = $urandom_range(0, 4);
            pkt_q = {8'h57, 8'($urandom), 8'($urandom), 8'($urandom),
                     8'(len), 8'h00};
            for (int j = 0; j < len; j++) pkt_q.push_back(8'($urandom));
            run_packet(6 + len);
        end

        // reset in the middle of a data byte
        pkt_q = {8'h57, 8'h00, 8'h10, 8'h00, 8'h03, 8'h00,
                 8'hA1, 8'hA2, 8'hA3};
        ok = model_packet(7);
        for (int i = 0; i < 7; i++) send_byte(pkt_q[i], 1'b1);
        @(negedge clock);
        rx = 1'b0;
        repeat (5 * CPB) @(negedge clock);
        check("pre_rst_busy", busy, 1);
        reset = 1'b1;
        @(negedge clock);
        check("mid_rst_address", address, 0);
        check("mid_rst_out", out, 0);
        check("mid_rst_we", we, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_error", error, 0);
        check("mid_rst_tx", tx, 1);
        rx = 1'b1;
        reset = 1'b0;
        repeat (20 * CPB) @(negedge clock);
        check("post_rst_busy", busy, 0);

        check("pending_writes", exp_q.size(), 0);
        check("pending_acks", ack_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
